// File: rtl/serial_addsub_pkg.sv
// Shared constants and types for the serial adder/subtractor: operation modes and
// FSM state encoding.
package serial_addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of clock slices needed to cover a full operand.
  function automatic int slice_count(input int width, input int bits_per_cyc);
    return width / bits_per_cyc;
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Operand/result bus of the serial adder/subtractor with requester and unit views.
interface serial_addsub_if #(
  parameter int WIDTH = 8
) ();

  // Handshake: start is taken on any rising edge where busy==0 (IDLE or DONE), and
  // mode/a/b/cin are sampled on that same edge. busy stays high while slices are being
  // processed; done pulses for exactly one cycle and result/cout/ovf are valid from it.
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, mode, a, b, cin,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, mode, a, b, cin,
    output busy, done, result, cout, ovf
  );

endinterface

// File: rtl/serial_addsub_fa_hs_cell.sv
// Full-adder cell composed of two half-subtractor stages: a+b+c is evaluated as
// a-(~b)-(~c), so the sum is the final difference and the carry is the inverted borrow.
module fa_hs_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  logic diff_1;
  logic borrow_1;
  logic diff_2;
  logic borrow_2;

  // Stage 1: a - (~b)
  assign diff_1   = a ^ ~b;
  assign borrow_1 = ~a & ~b;

  // Stage 2: diff_1 - (~c)
  assign diff_2   = diff_1 ^ ~c;
  assign borrow_2 = ~diff_1 & ~c;

  assign sum   = diff_2;
  assign carry = ~(borrow_1 | borrow_2);

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: a ripple slice of BITS_PER_CYC full-adder cells walks
// the operands LSB first, one slice per clock, with a start/busy/done handshake.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int BITS_PER_CYC = 1
) (
  input  logic     clk,
  input  logic     rst,
  serial_addsub_if.slave bus,
  output state_t   dbg_state
);

  localparam int N     = slice_count(WIDTH, BITS_PER_CYC);
  localparam int CNT_W = $clog2(N) + 1;

  state_t state_q;
  state_t state_next;

  logic [WIDTH-1:0]        a_sh;
  logic [WIDTH-1:0]        b_sh;
  logic [WIDTH-1:0]        acc;
  logic [WIDTH-1:0]        acc_next;
  logic [WIDTH-1:0]        result_q;
  logic                    carry_q;
  logic                    mode_q;
  logic                    cout_q;
  logic                    ovf_q;
  logic [CNT_W-1:0]        cnt;
  logic [BITS_PER_CYC-1:0] sum;
  logic [BITS_PER_CYC:0]   chain;
  logic                    accept;
  logic                    last;

  assign accept = bus.start && (state_q != ST_RUN);
  assign last   = (state_q == ST_RUN) && (cnt == CNT_W'(N - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.start) state_next = ST_RUN;
      ST_RUN:  if (last)      state_next = ST_DONE;
      ST_DONE: state_next = bus.start ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- slice datapath
  assign chain[0] = carry_q;

  for (genvar i = 0; i < BITS_PER_CYC; i++) begin : g_cell
    fa_hs_cell u_cell (
      .a     (a_sh[i]),
      .b     (b_sh[i]),
      .c     (chain[i]),
      .sum   (sum[i]),
      .carry (chain[i+1])
    );
  end

  // Sum bits enter at the MSB end so the LSB slice ends up at bit 0 after N shifts.
  if (N == 1) begin : g_acc_single
    assign acc_next = sum;
  end else begin : g_acc_shift
    assign acc_next = {sum, acc[WIDTH-1:BITS_PER_CYC]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      carry_q  <= 1'b0;
      mode_q   <= MODE_ADD;
      cnt      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      // Subtraction runs as a + ~b + ~borrow_in through the same adder slice.
      a_sh    <= bus.a;
      b_sh    <= bus.b ^ {WIDTH{bus.mode == MODE_SUB}};
      mode_q  <= bus.mode;
      carry_q <= bus.cin ^ bus.mode;
      acc     <= '0;
      cnt     <= '0;
    end else if (state_q == ST_RUN) begin
      a_sh    <= a_sh >> BITS_PER_CYC;
      b_sh    <= b_sh >> BITS_PER_CYC;
      acc     <= acc_next;
      carry_q <= chain[BITS_PER_CYC];
      cnt     <= cnt + CNT_W'(1);
      if (last) begin
        result_q <= acc_next;
        cout_q   <= chain[BITS_PER_CYC] ^ mode_q;
        ovf_q    <= chain[BITS_PER_CYC-1] ^ chain[BITS_PER_CYC];
      end
    end
  end

  assign bus.busy   = (state_q == ST_RUN);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: 1-bit and 4-bit slice instances checked against an
// integer-arithmetic reference model.
module tb_serial_addsub;
  import serial_addsub_pkg::*;

  logic   clk;
  logic   rst;
  state_t state1;
  state_t state4;
  int     checks;
  int     failures;

  serial_addsub_if #(.WIDTH(8)) bus1 ();
  serial_addsub_if #(.WIDTH(8)) bus4 ();

  serial_addsub #(.WIDTH(8), .BITS_PER_CYC(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_state(state1)
  );
  serial_addsub #(.WIDTH(8), .BITS_PER_CYC(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .dbg_state(state4)
  );

  // ---------------------------------------------------------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, cout, result} from plain integer arithmetic.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic mode);
    int r;
    int s;
    logic [7:0] res;
    logic co;
    logic ov;
    if (mode == MODE_ADD) begin
      r  = int'(a) + int'(b) + int'(cin);
      s  = int'($signed(a)) + int'($signed(b)) + int'(cin);
      co = (r > 255);
    end else begin
      r  = int'(a) - int'(b) - int'(cin);
      s  = int'($signed(a)) - int'($signed(b)) - int'(cin);
      co = (r < 0);
    end
    res = r[7:0];
    ov  = (s > 127) || (s < -128);
    return {ov, co, res};
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic mode, output logic [9:0] got, output int lat,
                     output int busy_bad, output int unstable);
    logic [9:0] held;
    @(negedge clk);
    held = {bus1.ovf, bus1.cout, bus1.result};
    bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.mode = mode; bus1.start = 1'b1;
    lat = 0; busy_bad = 0; unstable = 0;
    do begin
      @(negedge clk);
      lat++;
      bus1.start = 1'b0;
      if (!bus1.done) begin
        if (!bus1.busy) busy_bad++;
        if ({bus1.ovf, bus1.cout, bus1.result} !== held) unstable++;
      end
    end while (!bus1.done && lat < 40);
    got = {bus1.ovf, bus1.cout, bus1.result};
  endtask

  task automatic op4(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic mode, output logic [9:0] got, output int lat,
                     output int busy_bad);
    @(negedge clk);
    bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.mode = mode; bus4.start = 1'b1;
    lat = 0; busy_bad = 0;
    do begin
      @(negedge clk);
      lat++;
      bus4.start = 1'b0;
      if (!bus4.done && !bus4.busy) busy_bad++;
    end while (!bus4.done && lat < 40);
    got = {bus4.ovf, bus4.cout, bus4.result};
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    bus1.start = 1'b0; bus1.mode = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    bus4.start = 1'b0; bus4.mode = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus1.busy, bus1.done, bus1.cout, bus1.ovf, bus1.result} !== 12'h000) begin
      failures++;
      $display("FAIL reset_dut1: got busy=%b done=%b cout=%b ovf=%b result=%h, want all 0",
               bus1.busy, bus1.done, bus1.cout, bus1.ovf, bus1.result);
    end
    checks++;
    if ({bus4.busy, bus4.done, bus4.cout, bus4.ovf, bus4.result} !== 12'h000) begin
      failures++;
      $display("FAIL reset_dut4: got busy=%b done=%b cout=%b ovf=%b result=%h, want all 0",
               bus4.busy, bus4.done, bus4.cout, bus4.ovf, bus4.result);
    end
    checks++;
    if (state1 !== ST_IDLE || state4 !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d/%0d, want %0d", state1, state4, ST_IDLE);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] va[4]    = '{8'h7F, 8'h00, 8'h80, 8'hFF};
    logic [7:0] vb[4]    = '{8'h01, 8'h01, 8'h01, 8'h00};
    logic       vc[4]    = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       vm[4]    = '{MODE_ADD, MODE_SUB, MODE_SUB, MODE_ADD};
    logic [9:0] want[4]  = '{{1'b1, 1'b0, 8'h80}, {1'b0, 1'b1, 8'hFF},
                             {1'b1, 1'b0, 8'h7F}, {1'b0, 1'b1, 8'h00}};
    logic [9:0] got;
    int lat, busy_bad, unstable;
    for (int i = 0; i < 4; i++) begin
      op1(va[i], vb[i], vc[i], vm[i], got, lat, busy_bad, unstable);
      checks++;
      if (got !== want[i] || got !== model(va[i], vb[i], vc[i], vm[i])) begin
        failures++;
        $display("FAIL directed_%0d: got {ovf,cout,result}=%h, want %h", i, got, want[i]);
      end
      checks++;
      if (lat !== 9 || busy_bad !== 0) begin
        failures++;
        $display("FAIL directed_latency_%0d: got done at %0d (busy gaps %0d), want 9 (0)",
                 i, lat, busy_bad);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic cin, mode;
    logic [9:0] got, want;
    int lat, busy_bad, unstable;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1)); mode = 1'($urandom_range(0, 1));
      want = model(a, b, cin, mode);
      op1(a, b, cin, mode, got, lat, busy_bad, unstable);
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL random_%0d: a=%h b=%h cin=%b mode=%b got %h, want %h",
                 i, a, b, cin, mode, got, want);
      end
      checks++;
      if (lat !== 9 || busy_bad !== 0 || unstable !== 0) begin
        failures++;
        $display("FAIL random_timing_%0d: lat=%0d busy_gaps=%0d changes=%0d, want 9/0/0",
                 i, lat, busy_bad, unstable);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [9:0] want;
    int lat;
    want = model(8'h5A, 8'h33, 1'b1, MODE_ADD);
    @(negedge clk);
    bus1.a = 8'h5A; bus1.b = 8'h33; bus1.cin = 1'b1; bus1.mode = MODE_ADD; bus1.start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus1.start = 1'b0;
      if (lat == 3) begin
        bus1.a = 8'h11; bus1.b = 8'hEE; bus1.cin = 1'b0; bus1.mode = MODE_SUB;
        bus1.start = 1'b1;
      end
    end while (!bus1.done && lat < 40);
    checks++;
    if ({bus1.ovf, bus1.cout, bus1.result} !== want) begin
      failures++;
      $display("FAIL ignore_start_result: got %h, want %h",
               {bus1.ovf, bus1.cout, bus1.result}, want);
    end
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("FAIL ignore_start_latency: got %0d, want 9", lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int late_done;
    @(negedge clk);
    bus1.a = 8'hC3; bus1.b = 8'h21; bus1.cin = 1'b0; bus1.mode = MODE_ADD; bus1.start = 1'b1;
    lat = 0;
    while (lat < 4) begin
      @(negedge clk);
      lat++;
      bus1.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus1.busy, bus1.done, bus1.cout, bus1.ovf, bus1.result} !== 12'h000) begin
      failures++;
      $display("FAIL reset_mid: got busy=%b done=%b cout=%b ovf=%b result=%h, want all 0",
               bus1.busy, bus1.done, bus1.cout, bus1.ovf, bus1.result);
    end
    late_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus1.done || bus1.busy) late_done++;
    end
    checks++;
    if (late_done !== 0 || bus1.result !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_after: activity cycles=%0d result=%h, want 0 and 00",
               late_done, bus1.result);
    end
  endtask

  task automatic test_wide_slice();
    logic [7:0] a, b;
    logic cin, mode;
    logic [9:0] got, want;
    int lat, busy_bad;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin
        a = 8'h3C; b = 8'h0F; cin = 1'b0; mode = MODE_ADD;
      end else begin
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
        cin = 1'($urandom_range(0, 1)); mode = 1'($urandom_range(0, 1));
      end
      want = model(a, b, cin, mode);
      op4(a, b, cin, mode, got, lat, busy_bad);
      checks++;
      if (got !== want || (i == 0 && got[7:0] !== 8'h4B)) begin
        failures++;
        $display("FAIL wide_slice_%0d: a=%h b=%h cin=%b mode=%b got %h, want %h",
                 i, a, b, cin, mode, got, want);
      end
      checks++;
      if (lat !== 3 || busy_bad !== 0) begin
        failures++;
        $display("FAIL wide_slice_latency_%0d: got %0d (busy gaps %0d), want 3 (0)",
                 i, lat, busy_bad);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] got, want1, want2;
    int lat, busy_bad, unstable;
    want1 = model(8'h9C, 8'h64, 1'b0, MODE_SUB);
    want2 = model(8'h40, 8'h40, 1'b1, MODE_ADD);
    op1(8'h9C, 8'h64, 1'b0, MODE_SUB, got, lat, busy_bad, unstable);
    checks++;
    if (got !== want1 || lat !== 9) begin
      failures++;
      $display("FAIL b2b_first: got %h at %0d, want %h at 9", got, lat, want1);
    end
    // Still inside the DONE cycle: request the next operation.
    bus1.a = 8'h40; bus1.b = 8'h40; bus1.cin = 1'b1; bus1.mode = MODE_ADD; bus1.start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus1.start = 1'b0;
      if (lat == 1) begin
        checks++;
        if (bus1.busy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_no_gap: got busy=%b after DONE-cycle start, want 1", bus1.busy);
        end
      end
    end while (!bus1.done && lat < 40);
    checks++;
    if ({bus1.ovf, bus1.cout, bus1.result} !== want2 || lat !== 9) begin
      failures++;
      $display("FAIL b2b_second: got %h at %0d, want %h at 9",
               {bus1.ovf, bus1.cout, bus1.result}, lat, want2);
    end
  endtask

  // ---------------------------------------------------------------- sequence / report
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_wide_slice();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
